// File: rtl/pipeline_stage_reg_pkg.sv
// Shared pipeline-register constants: control-field layout, NOP encoding and
// per-stage bundle widths.
package pipeline_stage_reg_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 16;

    localparam int IFID_DATA_W = 64;
    localparam int IFID_CTRL_W = 16;
    localparam int IDEX_DATA_W = 64;
    localparam int IDEX_CTRL_W = 16;

    localparam int CTRL_ALU_OP_LSB   = 0;
    localparam int CTRL_ALU_OP_W     = 4;
    localparam int CTRL_ALU_SRCB_LSB = 4;
    localparam int CTRL_ALU_SRCB_W   = 2;
    localparam int CTRL_REG_DST      = 6;
    localparam int CTRL_MEMTOREG     = 7;
    localparam int CTRL_REG_WRITE    = 8;
    localparam int CTRL_MEM_READ     = 9;
    localparam int CTRL_MEM_WRITE    = 10;
    localparam int CTRL_HALT         = 11;
    localparam int CTRL_OUTPUT       = 12;

    localparam logic [CTRL_ALU_OP_W-1:0] OPCODE_NOP = '0;

    // A NOP selects the NOP ALU op with every write/memory/halt strobe cleared.
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP =
        CTRL_W_DEF'(OPCODE_NOP) << CTRL_ALU_OP_LSB;

    function automatic bit depth_is_legal(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus control and data payload, with
// load and clear (clear wins).
module pipe_entry_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, stall, flush and
// bubble; DEPTH=2 adds a skid entry so in_ready does not depend on out_ready.
module pipeline_stage_reg
    import pipeline_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP),
    parameter int                DEPTH    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("pipeline_stage_reg: DEPTH must be 1 or 2");
    end

    logic              head_valid, skid_valid;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_d;
    logic [DATA_W-1:0] head_data, skid_data, head_data_d;
    logic              head_load, head_clr, skid_load, skid_clr;
    logic              room, push, pop;

    always_comb begin
        if (DEPTH == 1) room = ~head_valid | out_ready;
        else            room = ~(head_valid & skid_valid);
    end

    assign in_ready = reset_n & ~stall & ~flush & ~bubble & room;
    assign push     = in_valid & in_ready;
    assign pop      = head_valid & out_ready & ~stall & ~flush;

    // Skid always refills the head first, which keeps the order strictly FIFO.
    always_comb begin
        head_load   = 1'b0;
        head_clr    = 1'b0;
        skid_load   = 1'b0;
        skid_clr    = 1'b0;
        head_ctrl_d = in_ctrl;
        head_data_d = in_data;
        if (flush) begin
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (pop) begin
            if (skid_valid) begin
                head_load   = 1'b1;
                head_ctrl_d = skid_ctrl;
                head_data_d = skid_data;
                skid_load   = push;
                skid_clr    = ~push;
            end else begin
                head_load = push;
                head_clr  = ~push;
            end
        end else if (push) begin
            head_load = ~head_valid;
            skid_load = head_valid;
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (head_load),
        .clear_i (head_clr),
        .ctrl_i  (head_ctrl_d),
        .data_i  (head_data_d),
        .valid_o (head_valid),
        .ctrl_o  (head_ctrl),
        .data_o  (head_data)
    );

    if (DEPTH == 2) begin : g_skid
        pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (skid_load),
            .clear_i (skid_clr),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );
    end else begin : g_no_skid
        logic unused_skid;
        assign unused_skid = skid_load | skid_clr;
        assign skid_valid  = 1'b0;
        assign skid_ctrl   = '0;
        assign skid_data   = '0;
    end

    assign out_valid = head_valid;
    assign out_ctrl  = head_valid ? head_ctrl : NOP_CTRL;
    assign out_data  = head_valid ? head_data : '0;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: one DEPTH=1 and one DEPTH=2 instance
// sharing the same input stimulus, each checked against its own vector table.
module tb_pipeline_stage_reg;

    localparam logic [7:0] NOP = 8'hF0;

    logic        clk = 1'b0;
    logic        reset_n, flush, stall, bubble, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [15:0] in_data;

    logic        o1_ready, o1_valid, o2_ready, o2_valid;
    logic [7:0]  o1_ctrl, o2_ctrl;
    logic [15:0] o1_data, o2_data;
    logic [1:0]  o1_occ, o2_occ;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(16), .CTRL_W(8), .NOP_CTRL(NOP), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_ready(o1_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o1_valid), .out_ready(out_ready), .out_ctrl(o1_ctrl),
        .out_data(o1_data), .occupancy(o1_occ)
    );

    pipeline_stage_reg #(.DATA_W(16), .CTRL_W(8), .NOP_CTRL(NOP), .DEPTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_ready(o2_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o2_valid), .out_ready(out_ready), .out_ctrl(o2_ctrl),
        .out_data(o2_data), .occupancy(o2_occ)
    );

    typedef struct {
        string       tag;
        bit          fl, st, bu, iv;
        logic [7:0]  ictrl;
        logic [15:0] idata;
        bit          ord;
        bit          exp_rdy, exp_ov;
        logic [7:0]  exp_oc;
        logic [15:0] exp_od;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];

    function automatic vec_t mk(input string tag, input bit fl, input bit st, input bit bu,
                                input bit iv, input logic [7:0] c, input logic [15:0] d,
                                input bit ord, input bit rdy, input bit ov,
                                input logic [7:0] oc, input logic [15:0] od,
                                input logic [1:0] occ);
        vec_t v;
        v.tag = tag; v.fl = fl; v.st = st; v.bu = bu; v.iv = iv;
        v.ictrl = c; v.idata = d; v.ord = ord;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_oc = oc; v.exp_od = od; v.exp_occ = occ;
        return v;
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic check_outs(input int dsel, input string tag, input bit ov,
                              input logic [7:0] oc, input logic [15:0] od,
                              input logic [1:0] occ);
        if (dsel == 1) begin
            check(tag, "out_valid", 16'(o1_valid), 16'(ov));
            check(tag, "out_ctrl",  16'(o1_ctrl),  16'(oc));
            check(tag, "out_data",  o1_data,       od);
            check(tag, "occupancy", 16'(o1_occ),   16'(occ));
        end else begin
            check(tag, "out_valid", 16'(o2_valid), 16'(ov));
            check(tag, "out_ctrl",  16'(o2_ctrl),  16'(oc));
            check(tag, "out_data",  o2_data,       od);
            check(tag, "occupancy", 16'(o2_occ),   16'(occ));
        end
    endtask

    task automatic check_ready(input int dsel, input string tag, input bit rdy);
        check(tag, "in_ready", 16'(dsel == 1 ? o1_ready : o2_ready), 16'(rdy));
    endtask

    // Entered 1 ns after a rising edge; returns 1 ns after the next one.
    task automatic apply(input int dsel, input vec_t v);
        flush = v.fl; stall = v.st; bubble = v.bu; in_valid = v.iv;
        in_ctrl = v.ictrl; in_data = v.idata; out_ready = v.ord;
        #1;
        check_ready(dsel, v.tag, v.exp_rdy);
        @(posedge clk);
        #1;
        check_outs(dsel, v.tag, v.exp_ov, v.exp_oc, v.exp_od, v.exp_occ);
    endtask

    task automatic idle_inputs();
        flush = 0; stall = 0; bubble = 0; in_valid = 0; out_ready = 0;
        in_ctrl = '0; in_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();

        for (int k = 1; k <= 8; k++)
            tab1.push_back(mk($sformatf("d1_stream%0d", k), 0, 0, 0, 1, 8'(k), 16'(k), 1,
                              1, 1, 8'(k), 16'(k), 2'd1));
        tab1.push_back(mk("d1_drain",       0,0,0,0, 8'h00,16'h0000,1, 1,0,NOP,  16'h0000,2'd0));
        tab1.push_back(mk("d1_fill",        0,0,0,1, 8'h33,16'h0033,0, 1,1,8'h33,16'h0033,2'd1));
        tab1.push_back(mk("d1_full_hold",   0,0,0,1, 8'h44,16'h0044,0, 0,1,8'h33,16'h0033,2'd1));
        tab1.push_back(mk("d1_replace",     0,0,0,1, 8'h44,16'h0044,1, 1,1,8'h44,16'h0044,2'd1));
        tab1.push_back(mk("d1_flush",       1,0,0,1, 8'hBB,16'h00BB,1, 0,0,NOP,  16'h0000,2'd0));
        tab1.push_back(mk("d1_post_flush",  0,0,0,0, 8'h00,16'h0000,0, 1,0,NOP,  16'h0000,2'd0));
        tab1.push_back(mk("d1_push55",      0,0,0,1, 8'h05,16'h0055,0, 1,1,8'h05,16'h0055,2'd1));
        for (int k = 0; k < 3; k++)
            tab1.push_back(mk($sformatf("d1_stall%0d", k), 0,1,0,1, 8'h66,16'h0066,1,
                              0,1,8'h05,16'h0055,2'd1));
        tab1.push_back(mk("d1_unstall",     0,0,0,0, 8'h00,16'h0000,1, 1,0,NOP,  16'h0000,2'd0));
        tab1.push_back(mk("d1_push10",      0,0,0,1, 8'h11,16'h0010,1, 1,1,8'h11,16'h0010,2'd1));
        tab1.push_back(mk("d1_bubble",      0,0,1,1, 8'h22,16'h0020,1, 0,0,NOP,  16'h0000,2'd0));
        tab1.push_back(mk("d1_post_bubble", 0,0,0,1, 8'h22,16'h0020,1, 1,1,8'h22,16'h0020,2'd1));
        tab1.push_back(mk("d1_drain2",      0,0,0,0, 8'h00,16'h0000,1, 1,0,NOP,  16'h0000,2'd0));

        tab2.push_back(mk("d2_pushA1",      0,0,0,1, 8'h01,16'h00A1,0, 1,1,8'h01,16'h00A1,2'd1));
        tab2.push_back(mk("d2_pushA2",      0,0,0,1, 8'h02,16'h00A2,0, 1,1,8'h01,16'h00A1,2'd2));
        tab2.push_back(mk("d2_fullA3",      0,0,0,1, 8'h03,16'h00A3,0, 0,1,8'h01,16'h00A1,2'd2));
        tab2.push_back(mk("d2_full_ord",    0,0,0,1, 8'h03,16'h00A3,1, 0,1,8'h02,16'h00A2,2'd1));
        tab2.push_back(mk("d2_popA2_pushA3",0,0,0,1, 8'h03,16'h00A3,1, 1,1,8'h03,16'h00A3,2'd1));
        tab2.push_back(mk("d2_popA3",       0,0,0,0, 8'h00,16'h0000,1, 1,0,NOP,  16'h0000,2'd0));
        tab2.push_back(mk("d2_pushB1",      0,0,0,1, 8'h11,16'h00B1,0, 1,1,8'h11,16'h00B1,2'd1));
        tab2.push_back(mk("d2_pushB2",      0,0,0,1, 8'h12,16'h00B2,0, 1,1,8'h11,16'h00B1,2'd2));
        tab2.push_back(mk("d2_popB1",       0,0,0,1, 8'h13,16'h00B3,1, 0,1,8'h12,16'h00B2,2'd1));
        tab2.push_back(mk("d2_pushB3",      0,0,0,1, 8'h13,16'h00B3,0, 1,1,8'h12,16'h00B2,2'd2));
        tab2.push_back(mk("d2_flush",       1,0,0,1, 8'hBB,16'h00BB,1, 0,0,NOP,  16'h0000,2'd0));
        tab2.push_back(mk("d2_post_flush",  0,0,0,0, 8'h00,16'h0000,0, 1,0,NOP,  16'h0000,2'd0));
        tab2.push_back(mk("d2_push55",      0,0,0,1, 8'h05,16'h0055,0, 1,1,8'h05,16'h0055,2'd1));
        for (int k = 0; k < 3; k++)
            tab2.push_back(mk($sformatf("d2_stall%0d", k), 0,1,0,1, 8'h66,16'h0066,1,
                              0,1,8'h05,16'h0055,2'd1));
        tab2.push_back(mk("d2_unstall",     0,0,0,0, 8'h00,16'h0000,1, 1,0,NOP,  16'h0000,2'd0));
        tab2.push_back(mk("d2_pushC1",      0,0,0,1, 8'h21,16'h00C1,0, 1,1,8'h21,16'h00C1,2'd1));
        tab2.push_back(mk("d2_pushC2",      0,0,0,1, 8'h22,16'h00C2,0, 1,1,8'h21,16'h00C1,2'd2));

        repeat (2) @(posedge clk);
        #1;
        check_outs(1, "reset_d1", 1'b0, NOP, 16'h0000, 2'd0);
        check_outs(2, "reset_d2", 1'b0, NOP, 16'h0000, 2'd0);
        check_ready(1, "reset_d1", 1'b0);
        check_ready(2, "reset_d2", 1'b0);
        reset_n = 1'b1;

        foreach (tab1[i]) apply(1, tab1[i]);

        idle_inputs();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        foreach (tab2[i]) apply(2, tab2[i]);

        // Asynchronous reset between edges while the skid stage is full.
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_outs(2, "d2_async_reset", 1'b0, NOP, 16'h0000, 2'd0);
        check_ready(2, "d2_async_reset", 1'b0);
        reset_n = 1'b1;
        #1;
        check_ready(2, "d2_reset_release", 1'b1);
        @(posedge clk);
        #1;
        apply(2, mk("d2_post_reset_push", 0,0,0,1, 8'h31,16'h00D1,1, 1,1,8'h31,16'h00D1,2'd1));

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
